// File: rtl/core_tlb_search_arbiter_pkg.sv
// rtl/core_tlb_search_arbiter_pkg.sv - shared translation types and search-arbiter FSM encoding
package core_tlb_search_arbiter_pkg;

    typedef struct packed {
        logic [9:0] asid;
    } csr_t;

    typedef struct packed {
        logic        found;
        logic [4:0]  index;
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_s_resp_t;

    typedef logic [3:0] tsa_state_t;

    localparam tsa_state_t TSA_IDLE  = 4'b0001;
    localparam tsa_state_t TSA_ISSUE = 4'b0010;
    localparam tsa_state_t TSA_WAIT  = 4'b0100;
    localparam tsa_state_t TSA_RESP  = 4'b1000;

    localparam logic SIDE_D = 1'b0;
    localparam logic SIDE_I = 1'b1;

endpackage

// File: rtl/core_rr_arb2.sv
// rtl/core_rr_arb2.sv - two-way round-robin arbiter, pointer moves past the winner on accept
module core_rr_arb2
    import core_tlb_search_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic ptr;

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) gnt_id = ptr;
        else              gnt_id = req[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  ptr <= SIDE_D;
        else if (accept && gnt_valid) ptr <= ~gnt_id;
    end

endmodule

// File: rtl/core_tlb_search_arbiter.sv
// rtl/core_tlb_search_arbiter.sv - shares the TLB search port between data and instruction translators
module core_tlb_search_arbiter
    import core_tlb_search_arbiter_pkg::*;
#(
    parameter int SEARCH_LATENCY = 1,
    parameter bit ENABLE_IFETCH  = 1'b1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  csr_t        csr_i,
    input  logic        flush_trans_i,
    input  logic        tlb_busy_i,
    input  logic        d_valid_i,
    input  logic [19:0] d_vppn_i,
    output logic        d_ready_o,
    output tlb_s_resp_t d_resp_o,
    input  logic        i_valid_i,
    input  logic [19:0] i_vppn_i,
    output logic        i_ready_o,
    output tlb_s_resp_t i_resp_o,
    output logic        s_valid_o,
    output logic [19:0] s_vppn_o,
    output logic [9:0]  s_asid_o,
    input  tlb_s_resp_t s_resp_i
);

    localparam logic [1:0] CNT_LOAD = 2'(SEARCH_LATENCY - 1);
    localparam logic       IF_EN    = (ENABLE_IFETCH != 1'b0);

    tsa_state_t  state, state_nxt;
    logic [1:0]  cnt;
    logic        gnt_side;
    logic [1:0]  req;
    logic        arb_valid, arb_id, grant, capture;
    tlb_s_resp_t d_resp_q, i_resp_q;

    assign req     = {i_valid_i & IF_EN, d_valid_i};
    assign grant   = (state == TSA_IDLE) && arb_valid && !tlb_busy_i && !flush_trans_i;
    assign capture = (state == TSA_WAIT) && !flush_trans_i && (cnt == 2'd0);

    core_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .accept    (grant),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TSA_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TSA_IDLE:  if (grant) state_nxt = TSA_ISSUE;
            TSA_ISSUE: state_nxt = flush_trans_i ? TSA_IDLE : TSA_WAIT;
            TSA_WAIT: begin
                if (flush_trans_i)     state_nxt = TSA_IDLE;
                else if (cnt == 2'd0)  state_nxt = TSA_RESP;
            end
            TSA_RESP:  state_nxt = TSA_IDLE;
            default:   state_nxt = TSA_IDLE;
        endcase
    end

    // Requester inputs are latched at grant so later vppn/asid changes cannot disturb the search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 2'd0;
            gnt_side <= SIDE_D;
            s_vppn_o <= '0;
            s_asid_o <= '0;
            d_resp_q <= '0;
            i_resp_q <= '0;
        end else begin
            if (grant) begin
                gnt_side <= arb_id;
                s_vppn_o <= (arb_id == SIDE_I) ? i_vppn_i : d_vppn_i;
                s_asid_o <= csr_i.asid;
            end
            if (state == TSA_ISSUE)
                cnt <= CNT_LOAD;
            else if (state == TSA_WAIT && cnt != 2'd0)
                cnt <= cnt - 2'd1;
            if (capture) begin
                if (gnt_side == SIDE_I) i_resp_q <= s_resp_i;
                else                    d_resp_q <= s_resp_i;
            end
        end
    end

    always_comb begin
        s_valid_o = (state == TSA_ISSUE);
        d_ready_o = (state == TSA_RESP) && (gnt_side == SIDE_D) && d_valid_i && !flush_trans_i;
        i_ready_o = (state == TSA_RESP) && (gnt_side == SIDE_I) && i_valid_i && !flush_trans_i && IF_EN;
    end

    assign d_resp_o = d_resp_q;
    assign i_resp_o = IF_EN ? i_resp_q : '0;

endmodule
